// File: rtl/maze_ram_arbiter.sv
// maze_ram_arbiter
//   Shares one synchronous-read tile RAM between the VGA renderer (fixed
//   two-cycle read latency) and the game logic (req/ack handshake). After
//   reset, and on every clear_start pulse, it sweeps the whole RAM and writes
//   CLEAR_VAL to every address.
//
// Ports
//   clk, reset_n         clock, synchronous active-low reset
//   vid_active/vid_addr  renderer read request and address
//   vid_data/vid_valid   renderer read data, valid two cycles after request
//   gm_req/gm_we/gm_addr/gm_wdata  game request, held until gm_ack
//   gm_ack/gm_rdata      one-cycle completion pulse and read data
//   clear_start          start or restart a full clear
//   busy                 clear in progress
//   ram_en/ram_we/ram_addr/ram_wdata  RAM controls (combinational)
//   ram_rdata            RAM read data, valid the cycle after an enabled read
//   state_dbg            current arbiter state (0 = CLEAR, 1 = RUN)
//
// Handshake
//   The game side holds gm_req and its command stable until gm_ack. A grant
//   in cycle T acks in T+2; T+1 and T+2 count as in flight, so the next grant
//   can happen at T+3 at the earliest. The renderer has no back-pressure: a
//   request in cycle T while running always yields vid_valid in T+2.
module maze_ram_arbiter #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned DEPTH     = 1200,
  parameter int unsigned CLEAR_VAL = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              gm_req,
  input  logic              gm_we,
  input  logic [ADDR_W-1:0] gm_addr,
  input  logic [DATA_W-1:0] gm_wdata,
  output logic              gm_ack,
  output logic [DATA_W-1:0] gm_rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              state_dbg
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] CLR_DATA  = DATA_W'(CLEAR_VAL);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q;

  // Renderer pipeline: stage 1 = RAM read issued last cycle.
  logic              vid_p1_q;
  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_data_q;

  // Game pipeline: stage 1 = grant issued last cycle, ack stage follows.
  logic              gm_p1_q;
  logic              gm_p1_we_q;
  logic              gm_ack_q;
  logic [DATA_W-1:0] gm_rdata_q;

  logic              vid_go;
  logic              gm_go;
  logic              gm_inflight;

  assign gm_inflight = gm_p1_q | gm_ack_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vid_go    = 1'b0;
    gm_go     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state_q)
      ST_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = cnt_q;
        ram_wdata = CLR_DATA;
        if (clear_start) begin
          // Restart: this cycle's write still lands, sweep resumes at 0.
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (clear_start) begin
          // No RAM access this cycle; address 0 is written next cycle.
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (vid_active) begin
          vid_go   = 1'b1;
          ram_en   = 1'b1;
          ram_addr = vid_addr;
        end else if (gm_req && !gm_inflight) begin
          gm_go     = 1'b1;
          ram_en    = 1'b1;
          ram_we    = gm_we;
          ram_addr  = gm_addr;
          ram_wdata = gm_wdata;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase

    // Keep the RAM quiet while reset is asserted.
    if (!reset_n) begin
      vid_go    = 1'b0;
      gm_go     = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      vid_p1_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      gm_p1_q     <= 1'b0;
      gm_p1_we_q  <= 1'b0;
      gm_ack_q    <= 1'b0;
      gm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= (state_d == ST_CLEAR);
      vid_p1_q    <= vid_go;
      vid_valid_q <= vid_p1_q;
      if (vid_p1_q) begin
        vid_data_q <= ram_rdata;
      end
      // In-flight game accesses finish regardless of a clear starting.
      gm_p1_q  <= gm_go;
      gm_ack_q <= gm_p1_q;
      if (gm_go) begin
        gm_p1_we_q <= gm_we;
      end
      if (gm_p1_q && !gm_p1_we_q) begin
        gm_rdata_q <= ram_rdata;
      end
    end
  end

  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign gm_ack    = gm_ack_q;
  assign gm_rdata  = gm_rdata_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_maze_ram_arbiter.sv
// tb_maze_ram_arbiter
//   Drives maze_ram_arbiter against a behavioural synchronous-read RAM.
//   Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after
//   the rising edge (mid-cycle), so both registered and combinational outputs
//   reflect the current cycle.
module tb_maze_ram_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1200;

  logic              clk;
  logic              reset_n;
  logic              vid_active;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              gm_req;
  logic              gm_we;
  logic [ADDR_W-1:0] gm_addr;
  logic [DATA_W-1:0] gm_wdata;
  logic              gm_ack;
  logic [DATA_W-1:0] gm_rdata;
  logic              clear_start;
  logic              busy;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              state_dbg;

  maze_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CLEAR_VAL(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .vid_active(vid_active), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
    .gm_ack(gm_ack), .gm_rdata(gm_rdata),
    .clear_start(clear_start), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural tile RAM ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 4'hA;
    rdata_q = '0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        rdata_q <= mem[ram_addr];
    end
  end
  assign ram_rdata = rdata_q;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // ---------------- driver tasks (start and end at a cycle start) ----------------
  task automatic do_game(input string name, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp);
    int n;
    gm_req = 1'b1; gm_we = we; gm_addr = addr; gm_wdata = wdata;
    settle();
    n = 0;
    while (!ram_en && n < 20) begin
      next_cycle();
      settle();
      n++;
    end
    chk({name, "_grant"}, {ram_en, ram_we, ram_addr}, {1'b1, we, addr});
    if (we) chk({name, "_wdata"}, ram_wdata, wdata);
    next_cycle(); settle();
    chk({name, "_ack_t1"}, gm_ack, 1'b0);
    next_cycle(); settle();
    chk({name, "_ack_t2"}, gm_ack, 1'b1);
    if (!we) chk({name, "_rdata"}, gm_rdata, exp);
    next_cycle();
    gm_req = 1'b0;
  endtask

  task automatic do_vid(input string name, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    vid_active = 1'b1; vid_addr = addr;
    settle();
    chk({name, "_ram"}, {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, addr});
    next_cycle();
    vid_active = 1'b0;
    settle();
    chk({name, "_valid_t1"}, vid_valid, 1'b0);
    next_cycle(); settle();
    chk({name, "_valid_t2"}, {vid_valid, vid_data}, {1'b1, exp});
    next_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int                op;    // 0 game write, 1 game read, 2 renderer read
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;  // write data or expected read data
  } vec_t;

  vec_t vecs [10];

  initial begin
    int bad;
    int cnt;

    vecs[0] = '{0, 11'd37,   4'h5};
    vecs[1] = '{2, 11'd37,   4'h5};
    vecs[2] = '{0, 11'd0,    4'hF};
    vecs[3] = '{0, 11'd1199, 4'h3};
    vecs[4] = '{0, 11'd1200, 4'h9};  // beyond DEPTH: passed through unchanged
    vecs[5] = '{1, 11'd1200, 4'h9};
    vecs[6] = '{1, 11'd0,    4'hF};
    vecs[7] = '{2, 11'd1199, 4'h3};
    vecs[8] = '{1, 11'd500,  4'h0};
    vecs[9] = '{2, 11'd1,    4'h0};

    reset_n = 1'b0; vid_active = 1'b0; vid_addr = '0;
    gm_req = 1'b0; gm_we = 1'b0; gm_addr = '0; gm_wdata = '0; clear_start = 1'b0;

    // Reset state
    repeat (3) next_cycle();
    settle();
    chk("rst_busy", busy, 1'b1);
    chk("rst_outputs", {ram_en, ram_we, ram_addr, ram_wdata, vid_valid, vid_data, gm_ack, gm_rdata}, '0);
    chk("rst_state", state_dbg, 1'b0);

    // Power-up clear sweep
    next_cycle();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      if (!(ram_en && ram_we && ram_addr == 11'(i) && ram_wdata == 4'h0 && busy)) bad++;
      next_cycle();
    end
    chk("clear_sweep_errs", bad, 0);
    settle();
    chk("clear_done", {busy, ram_en, state_dbg}, {1'b0, 1'b0, 1'b1});
    next_cycle();

    // Table of single accesses
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].op == 2) do_vid($sformatf("vec%0d_vid", v), vecs[v].addr, vecs[v].data);
      else do_game($sformatf("vec%0d_gm", v), vecs[v].op == 0, vecs[v].addr, vecs[v].data, vecs[v].data);
    end

    // Renderer starves a pending game read for 100 cycles
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = 11'd37;
    vid_active = 1'b1; vid_addr = 11'd10;
    bad = 0; cnt = 0;
    for (int c = 0; c < 100; c++) begin
      settle();
      if (!ram_en || ram_we || ram_addr != 11'd10 || gm_ack) bad++;
      if (c >= 2 && vid_valid) begin
        cnt++;
        if (vid_data != 4'h0) bad++;
      end
      next_cycle();
    end
    chk("starve_errs", bad, 0);
    chk("starve_vid_valid_count", cnt, 98);
    vid_active = 1'b0;
    settle();
    chk("starve_grant", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 11'd37});
    next_cycle(); settle();
    chk("starve_ack_t1", gm_ack, 1'b0);
    next_cycle(); settle();
    chk("starve_ack_t2", {gm_ack, gm_rdata}, {1'b1, 4'h5});
    next_cycle();
    gm_req = 1'b0;

    // Three writes with gm_req held high: grants every 3 cycles
    gm_req = 1'b1; gm_we = 1'b1;
    bad = 0;
    for (int c = 0; c < 9; c++) begin
      gm_addr = 11'(100 + c / 3);
      gm_wdata = 4'(1 + c / 3);
      settle();
      if ((ram_en && ram_we) != (c % 3 == 0)) bad++;
      if (ram_en && (ram_addr != 11'(100 + c / 3) || ram_wdata != 4'(1 + c / 3))) bad++;
      if (gm_ack != (c % 3 == 2)) bad++;
      next_cycle();
    end
    chk("burst_errs", bad, 0);
    gm_req = 1'b0;
    settle();
    chk("burst_idle", {ram_en, gm_ack}, 2'b00);
    next_cycle();
    do_vid("burst_rd0", 11'd100, 4'h1);
    do_vid("burst_rd1", 11'd101, 4'h2);
    do_vid("burst_rd2", 11'd102, 4'h3);

    // Game read grant at T, clear_start at T+1
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = 11'd37;
    settle();
    chk("clr_rd_grant", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 11'd37});
    next_cycle();
    clear_start = 1'b1;
    settle();
    chk("clr_start_idle", {ram_en, gm_ack}, 2'b00);
    next_cycle();
    clear_start = 1'b0;
    settle();
    chk("clr_rd_ack", {gm_ack, gm_rdata}, {1'b1, 4'h5});
    chk("clr_first_write", {ram_en, ram_we, ram_addr, busy}, {1'b1, 1'b1, 11'd0, 1'b1});
    next_cycle();
    gm_req = 1'b0;

    // Sweep to 600, then restart
    bad = 0;
    for (int i = 1; i <= 600; i++) begin
      if (i == 600) clear_start = 1'b1;
      settle();
      if (!(ram_en && ram_we && ram_addr == 11'(i) && busy)) bad++;
      next_cycle();
    end
    clear_start = 1'b0;
    chk("clr_partial_errs", bad, 0);

    // Restarted sweep: renderer ignored, game read stays pending
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = 11'd37;
    bad = 0;
    for (int j = 0; j < DEPTH; j++) begin
      vid_active = (j < 5);
      vid_addr = 11'd37;
      settle();
      if (!(ram_en && ram_we && ram_addr == 11'(j) && ram_wdata == 4'h0 && busy)) bad++;
      if (vid_valid || gm_ack || vid_data != 4'h3) bad++;
      next_cycle();
    end
    vid_active = 1'b0;
    chk("clr_restart_errs", bad, 0);
    settle();
    chk("clr_restart_done", busy, 1'b0);
    chk("pending_grant", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 11'd37});
    next_cycle(); settle();
    chk("pending_ack_t1", gm_ack, 1'b0);
    next_cycle(); settle();
    chk("pending_ack_t2", {gm_ack, gm_rdata}, {1'b1, 4'h0});
    next_cycle();
    gm_req = 1'b0;
    do_vid("post_clear_vid", 11'd37, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/maze_ram_arbiter.md
# maze_ram_arbiter

Single-port arbiter and sequencer for the maze tile RAM in the VGA maze game. It shares one synchronous-read tile RAM between two requesters: the pixel renderer, which reads with fixed latency, and the game logic, which reads and writes through a req/ack handshake. It also runs a hardware clear sequence after reset and on command. It sits between the VGA renderer, the game FSM and the block RAM inside `fpga_top`.

## Interface
- `ADDR_W`, 11: tile address width.
- `DATA_W`, 4: tile code width.
- `DEPTH`, 1200: number of tiles (40x30); clear runs over addresses 0..DEPTH-1.
- `CLEAR_VAL`, 0: tile code written during clear.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `vid_active`  in  1  renderer requests a read this cycle.
- `vid_addr`  in  ADDR_W  renderer tile address.
- `vid_data`  out  DATA_W  renderer read data.
- `vid_valid`  out  1  `vid_data` is valid this cycle.
- `gm_req`  in  1  game access request; held high until `gm_ack`.
- `gm_we`  in  1  1 = write, 0 = read; stable while `gm_req` is high.
- `gm_addr`  in  ADDR_W  game address; stable while `gm_req` is high.
- `gm_wdata`  in  DATA_W  game write data; stable while `gm_req` is high.
- `gm_ack`  out  1  one-cycle completion pulse.
- `gm_rdata`  out  DATA_W  read data; valid with `gm_ack` for reads.
- `clear_start`  in  1  pulse that starts or restarts a full clear.
- `busy`  out  1  clear in progress.
- `ram_en`, `ram_we`  out  1  RAM enable and write enable (combinational).
- `ram_addr`  out  ADDR_W  RAM address (combinational).
- `ram_wdata`  out  DATA_W  RAM write data (combinational).
- `ram_rdata`  in  DATA_W  RAM read data; valid the cycle after an enabled read.

## Operation
- States are CLEAR and RUN. While `reset_n` is low, the state is CLEAR, the clear counter is 0, `busy`=1, and every other output is 0.
- CLEAR state:
  - Each cycle drives `ram_en`=1, `ram_we`=1, `ram_addr`=counter, `ram_wdata`=CLEAR_VAL, then increments the counter.
  - After writing DEPTH-1, moves to RAM and `busy` drops in the next cycle.
  - The renderer is ignored: no `vid_valid` is produced and `vid_data` holds its last value.
  - A game request stays pending; it is not granted and not acked.
- RUN state priority per cycle, highest first:
  - `clear_start` → enter CLEAR with counter 0. The clear write to address 0 happens in the next cycle.
  - `vid_active` → renderer read of `vid_addr`.
  - Game grant. Requires `gm_req`=1 and no game access in flight. Drives `gm_we`, `gm_addr` and `gm_wdata` to the RAM.
  - Otherwise idle: `ram_en`=0.
- Game handshake:
  - Grant in cycle T → `gm_ack`=1 in T+2.
  - For a read, `gm_rdata` is registered from `ram_rdata` and valid at T+2.
  - For a write, `gm_rdata` holds its previous value.
  - The access counts as in flight during T+1 and T+2, so no grant happens in those cycles even though `gm_req` is still high.
  - The earliest next grant is T+3, so maximum throughput is one access per 3 cycles.
  - `gm_req` dropping before ack is a protocol violation; the in-flight access still completes and acks.
- Renderer starvation of the game port is allowed. Blanking intervals, where `vid_active`=0, guarantee progress.
- `clear_start` while already in CLEAR restarts the counter at 0.
- `clear_start` during a game access in flight: the in-flight access still acks on schedule with its captured data. The clear begins the next cycle regardless.
- Addresses at or above DEPTH are passed to the RAM unchanged; the arbiter does no range check.

## Timing
- Renderer: `vid_active`=1 in cycle T with RAM → `vid_valid`=1 and `vid_data`=mem[`vid_addr`] at T+2. The path is pipelined, so back-to-back reads every cycle yield back-to-back valids.
- Game: grant to `gm_ack` is exactly 2 cycles. The request-to-grant delay depends on renderer and clear activity.
- Clear duration: DEPTH cycles of writes (1200 by default), counted from the first cycle after reset release or after `clear_start`.
- `vid_valid`, `gm_ack` and `busy` are registered outputs. `ram_*` outputs are combinational from state and inputs.

## Test plan
- Reset release → `busy`=1 for exactly 1200 cycles with `ram_addr` stepping 0..1199, all writes of 0. Then `busy`=0 and reads of any address return 0.
- In RAM, write 0x5 to address 37 via the game port → `gm_ack` 2 cycles after grant. A following renderer read of 37 gives `vid_valid` with `vid_data`=0x5 2 cycles later.
- `vid_active` held high for 100 cycles while `gm_req` (read of 37) is pending → no grant. The first cycle `vid_active`=0 grants, and `gm_ack` with `gm_rdata`=0x5 follows 2 cycles later.
- `gm_req` held high across 3 consecutive writes → grants are exactly 3 cycles apart, there is exactly one `gm_ack` per access, and no duplicate write occurs.
- `clear_start` pulsed mid-clear at counter 600 → counter restarts at 0 and `busy` stays high for a further 1200 cycles.
- Game read grant at T with `clear_start` at T+1 → `gm_ack` at T+2 returns the pre-clear data, and the clear writes begin at T+2.
